// File: rtl/softmax_pkg.sv
// ============================================================================
// Module      : softmax_pkg
// Description : Shared constants and FSM state type for the softmax forward
//               and gradient units (Q1.15 probability datapath).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package softmax_pkg;

    localparam int NUM_CLASSES = 10;
    localparam int DATA_W      = 16;

    // Largest positive Q1.15 value, used as "1.0"
    localparam logic [15:0] Q15_ONE = 16'h7FFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } sm_state_t;

endpackage

`default_nettype wire

// File: rtl/sat_sub_q15.sv
// ============================================================================
// Module      : sat_sub_q15
// Description : Combinational Q1.15 subtract. Both operands are treated as
//               non-negative, the difference is formed one bit wider and
//               saturated to the symmetric range [-MAX, +MAX].
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_sub_q15 #(
    parameter int W = 16
) (
    input  logic [W-1:0] minuend_i,
    input  logic [W-1:0] subtrahend_i,
    output logic [W-1:0] diff_o
);

    // Symmetric bounds: the most negative code is never produced
    localparam logic signed [W:0] C_MAX = {2'b00, {(W-1){1'b1}}};
    localparam logic signed [W:0] C_MIN = -C_MAX;

    logic signed [W:0] w_diff;

    assign w_diff = $signed({1'b0, minuend_i}) - $signed({1'b0, subtrahend_i});

    // Clip the wide difference into the representable signed range
    always_comb begin
        diff_o = w_diff[W-1:0];
        if (w_diff > C_MAX) begin
            diff_o = C_MAX[W-1:0];
        end else if (w_diff < C_MIN) begin
            diff_o = C_MIN[W-1:0];
        end
    end

endmodule

`default_nettype wire

// File: rtl/softmax_grad_unit.sv
// ============================================================================
// Module      : softmax_grad_unit
// Description : Cross-entropy softmax gradient (p - onehot(label)), argmax
//               prediction and saturating correct-prediction counter. One
//               class is processed per cycle; results are held until taken.
//               Optional macro SOFTMAX_GRAD_SCALE_EN: each gradient is
//               arithmetic-right-shifted by LR_SHIFT before registering.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module softmax_grad_unit #(
    parameter int NUM_CLASSES = softmax_pkg::NUM_CLASSES,
    parameter int DATA_W      = softmax_pkg::DATA_W,
    parameter int LR_SHIFT    = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_CLASSES*DATA_W-1:0] probs_in,
    input  logic [3:0]                    label,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [NUM_CLASSES*DATA_W-1:0] grad_out,
    output logic [3:0]                    pred_class,
    output logic                          correct,
    output logic                          label_err,
    output logic [15:0]                   correct_cnt,
    output logic                          out_valid,
    input  logic                          out_ready
);

    import softmax_pkg::*;

    localparam logic [DATA_W-1:0] C_ONE      = DATA_W'(Q15_ONE);
    localparam logic [3:0]        C_LAST_IDX = 4'(NUM_CLASSES - 1);

    sm_state_t                     state_q;
    logic [NUM_CLASSES*DATA_W-1:0] probs_q;
    logic [NUM_CLASSES*DATA_W-1:0] grad_q;
    logic [3:0]                    label_q;
    logic [3:0]                    idx_q;
    logic [3:0]                    best_idx_q;
    logic [DATA_W-1:0]             best_val_q;
    logic [3:0]                    pred_q;
    logic                          correct_q;
    logic                          label_err_q;
    logic [15:0]                   correct_cnt_q;
    logic                          out_valid_q;
    logic                          in_ready_q;

    logic [DATA_W-1:0] w_p_raw;
    logic [DATA_W-1:0] w_p;
    logic [DATA_W-1:0] w_onehot;
    logic [DATA_W-1:0] w_grad_sat;
    logic [DATA_W-1:0] w_grad_fin;
    logic              w_label_err;
    logic [3:0]        best_idx_d;
    logic [DATA_W-1:0] best_val_d;
    logic [15:0]       correct_cnt_d;

    // Current class probability; values with the sign bit set exceed 1.0
    // and are clamped so the datapath stays within Q1.15
    assign w_p_raw = probs_q[int'(idx_q)*DATA_W +: DATA_W];
    assign w_p     = w_p_raw[DATA_W-1] ? C_ONE : w_p_raw;

    assign w_label_err = (int'(label_q) >= NUM_CLASSES);
    assign w_onehot    = (!w_label_err && (idx_q == label_q)) ? C_ONE : '0;

    sat_sub_q15 #(
        .W (DATA_W)
    ) u_sat_sub (
        .minuend_i    (w_p),
        .subtrahend_i (w_onehot),
        .diff_o       (w_grad_sat)
    );

`ifdef SOFTMAX_GRAD_SCALE_EN
    assign w_grad_fin = $signed(w_grad_sat) >>> LR_SHIFT;
`else
    assign w_grad_fin = w_grad_sat;
`endif

    // Strict compare keeps the lowest index on ties
    assign best_idx_d = (w_p > best_val_q) ? idx_q : best_idx_q;
    assign best_val_d = (w_p > best_val_q) ? w_p   : best_val_q;

    assign correct_cnt_d = (correct_cnt_q == 16'hFFFF) ? correct_cnt_q
                                                        : correct_cnt_q + 16'd1;

    // Capture / scan / hold sequencing with all outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            probs_q       <= '0;
            grad_q        <= '0;
            label_q       <= '0;
            idx_q         <= '0;
            best_idx_q    <= '0;
            best_val_q    <= '0;
            pred_q        <= '0;
            correct_q     <= 1'b0;
            label_err_q   <= 1'b0;
            correct_cnt_q <= '0;
            out_valid_q   <= 1'b0;
            in_ready_q    <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        probs_q    <= probs_in;
                        label_q    <= label;
                        idx_q      <= '0;
                        best_val_q <= '0;
                        best_idx_q <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= SCAN;
                    end
                end
                SCAN: begin
                    grad_q[int'(idx_q)*DATA_W +: DATA_W] <= w_grad_fin;
                    best_idx_q <= best_idx_d;
                    best_val_q <= best_val_d;
                    if (idx_q == C_LAST_IDX) begin
                        pred_q      <= best_idx_d;
                        correct_q   <= !w_label_err && (best_idx_d == label_q);
                        label_err_q <= w_label_err;
                        out_valid_q <= 1'b1;
                        state_q     <= HOLD;
                    end else begin
                        idx_q <= idx_q + 4'd1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        if (correct_q) begin
                            correct_cnt_q <= correct_cnt_d;
                        end
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        idx_q       <= '0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign grad_out    = grad_q;
    assign pred_class  = pred_q;
    assign correct     = correct_q;
    assign label_err   = label_err_q;
    assign correct_cnt = correct_cnt_q;
    assign out_valid   = out_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_softmax_grad_unit.sv
// ============================================================================
// Module      : tb_softmax_grad_unit
// Description : Self-checking bench for softmax_grad_unit: directed vector
//               table, randomized vectors against a reference model, output
//               back-pressure and mid-scan reset sequences.
//               Honors SOFTMAX_GRAD_SCALE_EN (expects shifted gradients).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_softmax_grad_unit;

    localparam int NC       = 10;
    localparam int LR_SHIFT = 3;

    typedef struct {
        logic [15:0] probs [NC];
        logic [3:0]  label;
        logic [15:0] grad  [NC];   // unscaled expected gradient
        logic [3:0]  pred;
        logic        corr;
        logic        err;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [159:0] probs_in;
    logic [3:0]   label;
    logic         in_valid;
    logic         in_ready;
    logic [159:0] grad_out;
    logic [3:0]   pred_class;
    logic         correct;
    logic         label_err;
    logic [15:0]  correct_cnt;
    logic         out_valid;
    logic         out_ready;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] exp_cnt = '0;

    softmax_grad_unit #(
        .NUM_CLASSES (NC),
        .DATA_W      (16),
        .LR_SHIFT    (LR_SHIFT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .probs_in    (probs_in),
        .label       (label),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .grad_out    (grad_out),
        .pred_class  (pred_class),
        .correct     (correct),
        .label_err   (label_err),
        .correct_cnt (correct_cnt),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [159:0] pack(input logic [15:0] a [NC]);
        logic [159:0] r;
        r = '0;
        for (int i = 0; i < NC; i++) r[i*16 +: 16] = a[i];
        return r;
    endfunction

    // Floor division by 2**LR_SHIFT when the scaling option is built in
    function automatic logic [15:0] scale(input logic [15:0] g);
`ifdef SOFTMAX_GRAD_SCALE_EN
        int v;
        int d;
        v = int'($signed(g));
        d = 1 << LR_SHIFT;
        if (v >= 0) v = v / d;
        else        v = -((-v + d - 1) / d);
        return v[15:0];
`else
        return g;
`endif
    endfunction

    // Reference: gradient = clamp(p) - onehot(label) saturated, argmax by first maximum
    function automatic void model(input logic [15:0] p [NC], input logic [3:0] lab,
                                  output logic [15:0] g [NC], output logic [3:0] pred,
                                  output logic corr, output logic err);
        int best;
        int pc;
        int d;
        err  = (int'(lab) >= NC);
        best = 0;
        pred = 4'd0;
        for (int i = 0; i < NC; i++) begin
            pc = (int'(p[i]) > 32767) ? 32767 : int'(p[i]);
            d  = pc - ((!err && i == int'(lab)) ? 32767 : 0);
            if (d > 32767)  d = 32767;
            if (d < -32767) d = -32767;
            g[i] = d[15:0];
            if (pc > best) begin
                best = pc;
                pred = 4'(i);
            end
        end
        corr = !err && (pred == lab);
    endfunction

    task automatic apply(input vec_t v, input int hold, input bit noisy);
        logic [15:0]  eg [NC];
        logic [159:0] eg_p;
        int           lat;
        bit           seen;
        for (int i = 0; i < NC; i++) eg[i] = scale(v.grad[i]);
        eg_p = pack(eg);
        chk("in_ready_idle", 160'(in_ready), 160'(1'b1));
        probs_in = pack(v.probs);
        label    = v.label;
        in_valid = 1'b1;
        tick();
        if (noisy) begin
            probs_in = {5{$urandom()}};
            label    = 4'($urandom());
        end else begin
            in_valid = 1'b0;
        end
        out_ready = (hold == 0);
        seen = 1'b0;
        lat  = 0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            tick();
            if (out_valid === 1'b1) begin
                seen = 1'b1;
                lat  = k;
            end
        end
        in_valid = 1'b0;
        chk("out_valid_latency", 160'(lat), 160'(NC));
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'b1;
            probs_in = {5{$urandom()}};
            label    = 4'($urandom());
            tick();
            in_valid = 1'b0;
            chk("hold_out_valid", 160'(out_valid), 160'(1'b1));
            chk("hold_in_ready", 160'(in_ready), 160'(1'b0));
            chk("hold_grad", grad_out, eg_p);
            chk("hold_pred", 160'(pred_class), 160'(v.pred));
        end
        chk("grad_out", grad_out, eg_p);
        chk("pred_class", 160'(pred_class), 160'(v.pred));
        chk("correct", 160'(correct), 160'(v.corr));
        chk("label_err", 160'(label_err), 160'(v.err));
        chk("cnt_before", 160'(correct_cnt), 160'(exp_cnt));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        if (v.corr && exp_cnt != 16'hFFFF) exp_cnt++;
        chk("out_valid_after_xfer", 160'(out_valid), 160'(1'b0));
        chk("in_ready_after_xfer", 160'(in_ready), 160'(1'b1));
        chk("cnt_after", 160'(correct_cnt), 160'(exp_cnt));
        if (hold > 0) begin
            tick();
            chk("no_capture_from_hold", 160'(out_valid), 160'(1'b0));
            chk("idle_after_hold", 160'(in_ready), 160'(1'b1));
        end
    endtask

    initial begin
        vec_t tbl [6];
        vec_t v;
        bit   ov_seen;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        probs_in  = '0;
        label     = '0;

        // All 0x0CCC, label 3
        for (int i = 0; i < NC; i++) begin tbl[0].probs[i] = 16'h0CCC; tbl[0].grad[i] = 16'h0CCC; end
        tbl[0].label = 4'd3; tbl[0].grad[3] = 16'h8CCD;
        tbl[0].pred = 4'd0; tbl[0].corr = 1'b0; tbl[0].err = 1'b0;
        // Confident correct prediction on class 7
        for (int i = 0; i < NC; i++) begin tbl[1].probs[i] = 16'h00E3; tbl[1].grad[i] = 16'h00E3; end
        tbl[1].probs[7] = 16'h7000; tbl[1].label = 4'd7; tbl[1].grad[7] = 16'hF001;
        tbl[1].pred = 4'd7; tbl[1].corr = 1'b1; tbl[1].err = 1'b0;
        // Out-of-range label: gradient equals probabilities
        for (int i = 0; i < NC; i++) begin
            tbl[2].probs[i] = 16'h1000 + 16'(i * 16'h0111);
            tbl[2].grad[i]  = 16'h1000 + 16'(i * 16'h0111);
        end
        tbl[2].label = 4'd12; tbl[2].pred = 4'd9; tbl[2].corr = 1'b0; tbl[2].err = 1'b1;
        // Probability above 1.0 clamps to 0x7FFF
        for (int i = 0; i < NC; i++) begin tbl[3].probs[i] = 16'h0200; tbl[3].grad[i] = 16'h0200; end
        tbl[3].probs[2] = 16'hFFFF; tbl[3].label = 4'd2; tbl[3].grad[2] = 16'h0000;
        tbl[3].pred = 4'd2; tbl[3].corr = 1'b1; tbl[3].err = 1'b0;
        // Tie between classes 5 and 8 resolves to 5
        for (int i = 0; i < NC; i++) begin tbl[4].probs[i] = 16'h0010; tbl[4].grad[i] = 16'h0010; end
        tbl[4].probs[5] = 16'h4000; tbl[4].grad[5] = 16'h4000;
        tbl[4].probs[8] = 16'h4000; tbl[4].grad[8] = 16'hC001;
        tbl[4].label = 4'd8; tbl[4].pred = 4'd5; tbl[4].corr = 1'b0; tbl[4].err = 1'b0;
        // All zero, label 0
        for (int i = 0; i < NC; i++) begin tbl[5].probs[i] = 16'h0000; tbl[5].grad[i] = 16'h0000; end
        tbl[5].grad[0] = 16'h8001; tbl[5].label = 4'd0;
        tbl[5].pred = 4'd0; tbl[5].corr = 1'b1; tbl[5].err = 1'b0;

        // Reset values while held in reset
        repeat (3) @(posedge clk);
        #1;
        chk("rst_grad", grad_out, 160'd0);
        chk("rst_pred", 160'(pred_class), 160'd0);
        chk("rst_correct", 160'(correct), 160'd0);
        chk("rst_label_err", 160'(label_err), 160'd0);
        chk("rst_cnt", 160'(correct_cnt), 160'd0);
        chk("rst_out_valid", 160'(out_valid), 160'd0);
        #3 rst_n = 1'b1;
        tick();

        apply(tbl[0], 0, 1'b0);
        apply(tbl[1], 5, 1'b0);
        for (int t = 2; t < 6; t++) apply(tbl[t], 0, 1'b1);

        for (int r = 0; r < 30; r++) begin
            for (int i = 0; i < NC; i++) v.probs[i] = 16'($urandom_range(0, 32767));
            if ($urandom_range(0, 2) == 0) v.probs[$urandom_range(0, NC-1)] = 16'h7FFF;
            v.label = 4'($urandom_range(0, 15));
            model(v.probs, v.label, v.grad, v.pred, v.corr, v.err);
            apply(v, ($urandom_range(0, 3) == 0) ? 2 : 0, 1'($urandom_range(0, 1)));
        end

        // Reset while scanning class index 4
        chk("in_ready_before_reset_case", 160'(in_ready), 160'(1'b1));
        probs_in = pack(tbl[1].probs);
        label    = tbl[1].label;
        in_valid = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("midscan_rst_grad", grad_out, 160'd0);
        chk("midscan_rst_pred", 160'(pred_class), 160'd0);
        chk("midscan_rst_correct", 160'(correct), 160'd0);
        chk("midscan_rst_label_err", 160'(label_err), 160'd0);
        chk("midscan_rst_cnt", 160'(correct_cnt), 160'd0);
        chk("midscan_rst_out_valid", 160'(out_valid), 160'd0);
        exp_cnt = '0;
        tick();
        #2 rst_n = 1'b1;
        ov_seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (out_valid !== 1'b0) ov_seen = 1'b1;
        end
        out_ready = 1'b0;
        chk("midscan_no_out_valid", 160'(ov_seen), 160'd0);
        chk("midscan_in_ready", 160'(in_ready), 160'(1'b1));

        // Normal operation resumes after the abandoned vector
        apply(tbl[1], 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
